// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port data memory: the core has priority, and a starvation counter forces host bursts in.
// Optional `MEM_ARB_PERF_EN` adds saturating stall/grant performance counters.
module mem_arbiter #(
  parameter int AW         = 8,
  parameter int LW         = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [7:0]    core_wdata,
  output logic [7:0]    core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [LW-1:0] host_len,
  input  logic          host_wvalid,
  input  logic [7:0]    host_wdata,
  output logic          host_wready,
  output logic          host_rvalid,
  output logic [7:0]    host_rdata,
  output logic          host_done,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_dat_in,
  input  logic [7:0]    mem_dat_out,
  output logic [1:0]    state_dbg
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]   perf_stall_cnt,
  output logic [7:0]    perf_grant_cnt
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_CORE = 2'd0,
    S_HOST = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [LW-1:0] beat_cnt;
  logic [AW-1:0] burst_addr;
  logic          burst_we;
  logic          grant;
  logic          consume;

  // Handshake: a host write beat transfers on a cycle with host_wvalid && host_wready;
  // a read beat transfers every S_HOST cycle and is returned with host_rvalid one cycle later.
  assign grant   = (state == S_CORE) && host_req && (!core_req || starve_cnt == STARVE_LIM);
  assign consume = (state == S_HOST) && (!burst_we || host_wvalid);

  assign core_rdata = mem_dat_out;
  assign state_dbg  = state;

  always_comb begin
    mem_addr   = core_addr;
    mem_dat_in = core_wdata;
    mem_wr_en  = core_req && core_we;
    core_stall = 1'b0;
    if (state == S_HOST) begin
      mem_addr   = burst_addr;
      mem_dat_in = host_wdata;
      mem_wr_en  = burst_we && host_wvalid;
      core_stall = core_req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_CORE;
      starve_cnt  <= '0;
      beat_cnt    <= '0;
      burst_addr  <= '0;
      burst_we    <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      host_done   <= 1'b0;
      host_wready <= 1'b0;
    end else begin
      host_rvalid <= 1'b0;
      host_done   <= 1'b0;
      case (state)
        S_CORE: begin
          if (grant) begin
            starve_cnt  <= '0;
            beat_cnt    <= host_len;
            burst_addr  <= host_addr;
            burst_we    <= host_we;
            host_wready <= host_we;
            state       <= S_HOST;
          end else if (host_req && core_req && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        S_HOST: begin
          if (consume) begin
            burst_addr <= burst_addr + 1'b1;
            beat_cnt   <= beat_cnt - 1'b1;
            if (!burst_we) begin
              host_rvalid <= 1'b1;
              host_rdata  <= mem_dat_out;
            end
            // Last beat: the burst ends even if host_req has already dropped.
            if (beat_cnt == '0) begin
              state       <= S_DONE;
              host_done   <= 1'b1;
              host_wready <= 1'b0;
            end
          end
        end
        S_DONE:  state <= S_CORE;
        default: state <= S_CORE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_grant_cnt <= '0;
    end else begin
      if (core_stall && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (grant && perf_grant_cnt != 8'hFF) perf_grant_cnt <= perf_grant_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table-driven core accesses plus hand-written burst sequences.
// A behavioural combinational-read memory stands in for dat_mem.
module tb_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdata, core_rdata;
  logic       core_stall;
  logic       host_req, host_we;
  logic [7:0] host_addr;
  logic [3:0] host_len;
  logic       host_wvalid;
  logic [7:0] host_wdata;
  logic       host_wready, host_rvalid, host_done;
  logic [7:0] host_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_addr, mem_dat_in, mem_dat_out;
  logic [1:0] state_dbg;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [7:0]  perf_grant_cnt;
`endif

  logic [7:0] dmem [0:255];
  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
    .host_wvalid(host_wvalid), .host_wdata(host_wdata), .host_wready(host_wready),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_done(host_done),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_dat_in(mem_dat_in),
    .mem_dat_out(mem_dat_out), .state_dbg(state_dbg)
`ifdef MEM_ARB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_grant_cnt(perf_grant_cnt)
`endif
  );

  // Clock and memory model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_dat_out = dmem[mem_addr];
  always @(posedge clk) if (mem_wr_en) dmem[mem_addr] <= mem_dat_in;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  // Driver and checking helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_wr;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] rd_addr [4];
  logic [7:0] rd_data [4];
  logic       wv_pat  [4];
  int         waits;
  int         nbeat;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'h10, 8'hA5, 1'b1, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 8'h11, 8'h3C, 1'b1, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 8'h3C};
    vecs[4] = '{1'b0, 1'b1, 8'h12, 8'hFF, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 1'b1, 8'hFF, 8'h77, 1'b1, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h77};
    rd_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    rd_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    wv_pat  = '{1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    reset = 1'b0;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_len = 0;
    host_wvalid = 0; host_wdata = 0;

    // Reset state
    #2;
    chk("rst_state", state_dbg, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_done", host_done, 0);
    chk("rst_wready", host_wready, 0);
    chk("rst_stall", core_stall, 0);
    chk("rst_rdata", host_rdata, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Core-only accesses, host idle
    for (int i = 0; i < 8; i++) begin
      core_req = vecs[i].req; core_we = vecs[i].we;
      core_addr = vecs[i].addr; core_wdata = vecs[i].wdata;
      #2;
      chk($sformatf("vec%0d_wr_en", i), mem_wr_en, vecs[i].exp_wr);
      chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("vec%0d_stall", i), core_stall, 0);
      chk($sformatf("vec%0d_rdata", i), core_rdata, vecs[i].exp_rdata);
      tick();
    end
    core_req = 0; core_we = 0;

    // Starvation: core holds the port, host write len 3 to 0x40
    core_req = 1; core_we = 0; core_addr = 8'h20;
    host_req = 1; host_we = 1; host_addr = 8'h40; host_len = 4'd3;
    host_wvalid = 1; host_wdata = 8'hC0;
    waits = 0;
    while (state_dbg != 2'd1 && waits < 40) begin
      #2;
      chk("starve_no_stall", core_stall, 0);
      tick();
      waits++;
    end
    // 8 waiting cycles with the counter climbing, then the grant cycle
    chk("starve_core_cycles", waits, 9);
    for (int b = 0; b < 4; b++) begin
      host_wdata = 8'hC0 + 8'(b);
      #2;
      chk("starve_stall", core_stall, 1);
      chk("starve_wr_en", mem_wr_en, 1);
      chk("starve_addr", mem_addr, 8'h40 + 8'(b));
      chk("starve_dat_in", mem_dat_in, 8'hC0 + 8'(b));
      chk("starve_wready", host_wready, 1);
      chk("starve_done_early", host_done, 0);
      tick();
    end
    host_req = 0; host_wvalid = 0;
    #2;
    chk("starve_done_stall", core_stall, 0);
    chk("starve_done", host_done, 1);
    chk("starve_done_addr", mem_addr, 8'h20);
    chk("starve_done_state", state_dbg, 2);
    tick();
    #2;
    chk("starve_done_pulse", host_done, 0);
    chk("starve_back_state", state_dbg, 0);
    for (int b = 0; b < 4; b++) chk("starve_mem", dmem[8'h40 + 8'(b)], 8'hC0 + 8'(b));
`ifdef MEM_ARB_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, 4);
    chk("perf_grant_cnt", perf_grant_cnt, 1);
`endif
    core_req = 0;
    tick();

    // Host read burst wrapping through 0xFF -> 0x00, core idle
    for (int b = 0; b < 4; b++) dmem[rd_addr[b]] = rd_data[b];
    host_req = 1; host_we = 0; host_addr = 8'hFE; host_len = 4'd3;
    #2;
    chk("rd_grant_state", state_dbg, 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      #2;
      chk("rd_state", state_dbg, 1);
      chk("rd_addr", mem_addr, rd_addr[b]);
      chk("rd_wr_en", mem_wr_en, 0);
      chk("rd_rvalid", host_rvalid, b > 0);
      if (b > 0) chk("rd_rdata", host_rdata, rd_data[b-1]);
      chk("rd_done_early", host_done, 0);
      tick();
    end
    host_req = 0;
    #2;
    chk("rd_done", host_done, 1);
    chk("rd_last_rvalid", host_rvalid, 1);
    chk("rd_last_rdata", host_rdata, 8'h44);
    tick();
    #2;
    chk("rd_done_pulse", host_done, 0);
    chk("rd_rvalid_end", host_rvalid, 0);
    chk("rd_end_state", state_dbg, 0);
    tick();

    // Host write len 1 with gaps in host_wvalid
    host_req = 1; host_we = 1; host_addr = 8'h80; host_len = 4'd1; host_wvalid = 0;
    tick();
    nbeat = 0;
    for (int c = 0; c < 4; c++) begin
      host_wvalid = wv_pat[c];
      host_wdata = wv_pat[c] ? ((nbeat == 0) ? 8'hD1 : 8'hD2) : 8'hEE;
      #2;
      chk("gap_wr_en", mem_wr_en, wv_pat[c]);
      chk("gap_addr", mem_addr, 8'h80 + 8'(nbeat));
      chk("gap_wready", host_wready, 1);
      chk("gap_done_early", host_done, 0);
      if (wv_pat[c]) nbeat++;
      tick();
    end
    host_req = 0; host_wvalid = 0;
    #2;
    chk("gap_done", host_done, 1);
    chk("gap_wready_end", host_wready, 0);
    tick();
    #2;
    chk("gap_done_pulse", host_done, 0);
    chk("gap_mem0", dmem[8'h80], 8'hD1);
    chk("gap_mem1", dmem[8'h81], 8'hD2);
    chk("gap_mem2", dmem[8'h82], 8'h00);
    tick();

    // Reset asserted during the second beat of a 4-beat write
    host_req = 1; host_we = 1; host_addr = 8'h90; host_len = 4'd3;
    host_wvalid = 1; host_wdata = 8'hB0;
    tick();
    #2;
    chk("rst_burst_wr0", mem_wr_en, 1);
    tick();
    host_wdata = 8'hB1;
    #1;
    chk("rst_burst_wr1", mem_wr_en, 1);
    reset = 1'b0;
    #1;
    chk("rst_burst_wr_en", mem_wr_en, 0);
    chk("rst_burst_state", state_dbg, 0);
    chk("rst_burst_wready", host_wready, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      #2;
      chk("rst_burst_no_done", host_done, 0);
    end
    host_req = 0; host_wvalid = 0;
    tick();
    reset = 1'b1;
    core_req = 1; core_we = 0; core_addr = 8'h90;
    #2;
    chk("post_rst_stall", core_stall, 0);
    chk("post_rst_addr", mem_addr, 8'h90);
    chk("post_rst_rdata", core_rdata, 8'hB0);
    chk("post_rst_done", host_done, 0);
    chk("post_rst_unwritten", dmem[8'h91], 8'h00);
    tick();
    core_req = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
